ai_cache_refill_ctrl: RTL and testbench
=======================================

Name: ai_cache_refill_ctrl

Overview:
Miss/refill controller downstream of ai_cache. It accepts one line-miss request at a time and issues a single line-read request to backing memory. It then assembles the narrow response beats into one full cache line and hands the line back to the cache for installation. The block is single-outstanding, non-blocking on the memory side via valid/ready, and guarded by a response timeout.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 128, cache line width in bits (must equal ai_cache DATA_WIDTH)
MEM_DATA_WIDTH, 32, memory response beat width; DATA_WIDTH must be an integer multiple
TIMEOUT_CYCLES, 255, max idle cycles between response beats before abort (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
miss_valid  in  1  cache presents a miss
miss_addr  in  ADDR_WIDTH  byte address of missing access
miss_ready  out  1  controller can accept a miss
mem_req_valid  out  1  line-read request to memory
mem_req_addr  out  ADDR_WIDTH  line-aligned request address
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  response beat valid (no backpressure)
mem_rsp_data  in  MEM_DATA_WIDTH  response beat
fill_valid  out  1  assembled line available
fill_addr  out  ADDR_WIDTH  line-aligned address of fill
fill_data  out  DATA_WIDTH  assembled line
fill_ready  in  1  cache accepts fill
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset values: state IDLE; miss_ready=1; mem_req_valid=0; fill_valid=0; busy=0; timeout_err=0; mem_req_addr, fill_addr, fill_data = 0; beat and timeout counters = 0.
- Constants: BEATS = DATA_WIDTH/MEM_DATA_WIDTH (default 4); OFFS = log2(DATA_WIDTH/8) (default 4).
- Line alignment: captured address = miss_addr with bits [OFFS-1:0] forced to 0. mem_req_addr and fill_addr both carry the aligned value.
- FSM states: IDLE, REQ, COLLECT, FILL.
- IDLE:
  - miss_ready=1 (registered state decode only, no combinational path from inputs).
  - On miss_valid&&miss_ready, capture the aligned address, clear fill_data and the beat counter, and go to REQ next cycle.
- REQ:
  - mem_req_valid=1 with mem_req_addr stable until mem_req_ready.
  - On handshake, go to COLLECT and clear the timeout counter.
  - No timeout applies in REQ.
- COLLECT:
  - Each mem_rsp_valid cycle writes beat k into fill_data[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH], k = 0..BEATS-1, then increments k and clears the timeout counter.
  - After beat BEATS-1 is written, go to FILL.
  - Each cycle without a beat increments the timeout counter. When it reaches TIMEOUT_CYCLES, go to IDLE, pulse timeout_err for exactly one cycle (the first IDLE cycle), and produce no fill.
- FILL:
  - fill_valid=1 with fill_addr and fill_data stable until fill_ready.
  - On handshake, go to IDLE; miss_ready is 1 on the following cycle.
  - There is no timeout in FILL.
- Minimum latency, miss accept to fill_valid with mem_req_ready=1 and back-to-back beats: 1 (REQ) + BEATS beat cycles, i.e. fill_valid is asserted on cycle 2+BEATS after acceptance.
- mem_rsp_valid outside COLLECT is ignored and must not corrupt fill_data.
- miss_valid outside IDLE is ignored (miss_ready=0). The cache must hold its request.
- Simultaneous mem_rsp_valid on the cycle the timeout counter would expire: the beat wins and the counter clears.
- Reset mid-operation, in any state: next cycle is IDLE with all outputs at reset values. The in-flight line is discarded.

Decomposition:
- Shared package ai_cache_pkg holds:
  - the refill state enum typedef (IDLE, REQ, COLLECT, FILL);
  - localparam helpers for BEATS and OFFS;
  - a line-align function for addresses.
- One natural sub-module: ai_cache_beat_assembler (beat counter plus indexed line register, with clear/load inputs and a done output).
- The FSM and timeout counter stay in the top module.

Test Plan:
- Basic refill: miss_addr=0x0000_1238, mem_req_ready=1, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> mem_req_addr=0x0000_1230; fill_addr=0x0000_1230; fill_data=0x44444444_33333333_22222222_11111111; fill_valid on cycle 6 after accept.
- Request backpressure: mem_req_ready held low 5 cycles -> mem_req_valid stays 1 with mem_req_addr constant; no beats are accepted before the handshake; then normal fill.
- Gapped beats plus fill backpressure: 3 idle cycles between beats, fill_ready low 4 cycles -> correct line, fill_valid/fill_data stable, miss_ready=0 until the cycle after the fill handshake.
- Timeout: TIMEOUT_CYCLES=8, deliver 2 beats then stop -> timeout_err high for exactly 1 cycle, no fill_valid, miss_ready=1; a new miss at 0x40 then completes normally with no stale beat data.
- Stray inputs: mem_rsp_valid=1 with data 0xDEADBEEF in IDLE, and miss_valid in COLLECT -> ignored; the subsequent fill carries only the correct beats.
- Reset mid-COLLECT after 2 beats -> next cycle IDLE, fill_valid=0, busy=0, fill_data=0, miss_ready=1.

Source files
------------

// File: rtl/ai_cache_pkg.sv
// Shared types and helpers for the ai_cache refill path: refill state encoding,
// line geometry helpers and line-address alignment.
package ai_cache_pkg;

    typedef enum logic [1:0] {
        RS_IDLE    = 2'd0,
        RS_REQ     = 2'd1,
        RS_COLLECT = 2'd2,
        RS_FILL    = 2'd3
    } refill_state_e;

    localparam int unsigned MAX_ADDR_W = 64;

    function automatic int unsigned beats_of(input int unsigned line_w, input int unsigned beat_w);
        return line_w / beat_w;
    endfunction

    function automatic int unsigned offs_of(input int unsigned line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int unsigned offs);
        logic [MAX_ADDR_W-1:0] mask;
        mask = {MAX_ADDR_W{1'b1}} << offs;
        return addr & mask;
    endfunction

endpackage

// File: rtl/ai_cache_refill_ctrl_if.sv
// Miss, memory and fill handshakes between the cache, the refill controller
// and backing memory; master is the controller's view.
interface ai_cache_refill_ctrl_if #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned MEM_DATA_WIDTH = 32
);
    logic                      miss_valid;
    logic [ADDR_WIDTH-1:0]     miss_addr;
    logic                      miss_ready;
    logic                      mem_req_valid;
    logic [ADDR_WIDTH-1:0]     mem_req_addr;
    logic                      mem_req_ready;
    logic                      mem_rsp_valid;
    logic [MEM_DATA_WIDTH-1:0] mem_rsp_data;
    logic                      fill_valid;
    logic [ADDR_WIDTH-1:0]     fill_addr;
    logic [DATA_WIDTH-1:0]     fill_data;
    logic                      fill_ready;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        input  miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, fill_ready,
        output miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_addr, fill_data,
               busy, timeout_err
    );

    modport slave (
        output miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, fill_ready,
        input  miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_addr, fill_data,
               busy, timeout_err
    );
endinterface

// File: rtl/ai_cache_beat_assembler.sv
// Packs narrow memory beats into one cache line, lowest beat at the lowest bits.
module ai_cache_beat_assembler
    import ai_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned MEM_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      load_i,
    input  logic [MEM_DATA_WIDTH-1:0] beat_i,
    output logic [DATA_WIDTH-1:0]     line_o,
    output logic                      done_o
);
    localparam int unsigned BEATS = beats_of(DATA_WIDTH, MEM_DATA_WIDTH);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] line_q, line_d;
    logic                  last_s;

    assign last_s = (cnt_q == CNT_W'(BEATS - 1));
    assign done_o = load_i && !clear_i && last_s;
    assign line_o = line_q;

    // Next beat slot and line contents
    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            line_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            for (int k = 0; k < BEATS; k++) begin
                line_d[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] =
                    (cnt_q == CNT_W'(k)) ? beat_i : line_q[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            end
            cnt_d = last_s ? '0 : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Beat counter and line register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/ai_cache_refill_ctrl.sv
// Single-outstanding miss/refill controller: one line read per miss, beats packed
// into a line, line handed back to the cache; aborts on a response-gap timeout.
module ai_cache_refill_ctrl
    import ai_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    ai_cache_refill_ctrl_if.master bus
);
    localparam int unsigned OFFS = offs_of(DATA_WIDTH);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = RS_IDLE;
    localparam logic [1:0] S_REQ     = RS_REQ;
    localparam logic [1:0] S_COLLECT = RS_COLLECT;
    localparam logic [1:0] S_FILL    = RS_FILL;

    logic [1:0]            state_q, state_d;
    logic [TO_W-1:0]       to_q, to_d, to_inc_s;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, aligned_s;
    logic                  miss_ready_q, mem_req_valid_q, fill_valid_q, busy_q;
    logic                  timeout_err_q, timeout_err_d;
    logic                  asm_clear_s, asm_load_s, asm_done_s;
    logic [DATA_WIDTH-1:0] line_s;

    assign aligned_s = ADDR_WIDTH'(line_align(MAX_ADDR_W'(bus.miss_addr), OFFS));
    assign to_inc_s  = to_q + TO_W'(1);

    ai_cache_beat_assembler #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MEM_DATA_WIDTH (MEM_DATA_WIDTH)
    ) u_asm (
        .clk     (clk),
        .reset   (reset),
        .clear_i (asm_clear_s),
        .load_i  (asm_load_s),
        .beat_i  (bus.mem_rsp_data),
        .line_o  (line_s),
        .done_o  (asm_done_s)
    );

    // Refill sequencing and response-gap timeout
    always_comb begin
        state_d       = state_q;
        to_d          = to_q;
        addr_d        = addr_q;
        asm_clear_s   = 1'b0;
        asm_load_s    = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.miss_valid) begin
                    addr_d      = aligned_s;
                    asm_clear_s = 1'b1;
                    state_d     = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    to_d    = '0;
                    state_d = S_COLLECT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_COLLECT: begin
                // A beat arriving on the expiry cycle still counts
                if (bus.mem_rsp_valid) begin
                    asm_load_s = 1'b1;
                    to_d       = '0;
                    state_d    = asm_done_s ? S_FILL : S_COLLECT;
                end else if (to_inc_s == TO_W'(TIMEOUT_CYCLES)) begin
                    to_d          = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    to_d = to_inc_s;
                end
            end
            S_FILL: begin
                if (bus.fill_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and status outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            to_q            <= '0;
            addr_q          <= '0;
            miss_ready_q    <= 1'b1;
            mem_req_valid_q <= 1'b0;
            fill_valid_q    <= 1'b0;
            busy_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            to_q            <= to_d;
            addr_q          <= addr_d;
            miss_ready_q    <= (state_d == S_IDLE);
            mem_req_valid_q <= (state_d == S_REQ);
            fill_valid_q    <= (state_d == S_FILL);
            busy_q          <= (state_d != S_IDLE);
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign bus.miss_ready    = miss_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.fill_valid    = fill_valid_q;
    assign bus.fill_addr     = addr_q;
    assign bus.fill_data     = line_s;
    assign bus.busy          = busy_q;
    assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_ai_cache_refill_ctrl.sv
// Bench for ai_cache_refill_ctrl: directed scenarios plus randomized refills,
// checked every cycle against a transaction-level model of the refill rules.
module tb_ai_cache_refill_ctrl;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 128;
    localparam int unsigned MDW   = 32;
    localparam int unsigned TO    = 8;
    localparam int unsigned BEATS = DW / MDW;
    localparam int unsigned LINEB = DW / 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ai_cache_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DATA_WIDTH(MDW)) bus_if ();

    ai_cache_refill_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DATA_WIDTH(MDW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    bit chk_en   = 1'b0;

    // Model: what is outstanding, the line built so far, the current response gap
    bit              m_req, m_coll, m_fill, m_terr;
    int              m_nb, m_gap;
    logic [DW-1:0]   m_line;
    logic [AW-1:0]   m_addr;

    function automatic bit m_busy();
        return m_req || m_coll || m_fill;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        if (reset) begin
            m_req = 0; m_coll = 0; m_fill = 0; m_terr = 0;
            m_nb = 0; m_gap = 0; m_line = '0; m_addr = '0;
        end else begin
            m_terr = 0;
            if (!m_busy()) begin
                if (bus_if.miss_valid) begin
                    m_addr = (bus_if.miss_addr / AW'(LINEB)) * AW'(LINEB);
                    m_line = '0;
                    m_nb   = 0;
                    m_req  = 1;
                end
            end else if (m_req) begin
                if (bus_if.mem_req_ready) begin
                    m_req = 0; m_coll = 1; m_gap = 0;
                end
            end else if (m_coll) begin
                if (bus_if.mem_rsp_valid) begin
                    m_line[m_nb*MDW +: MDW] = bus_if.mem_rsp_data;
                    m_nb++;
                    m_gap = 0;
                    if (m_nb == BEATS) begin
                        m_coll = 0; m_fill = 1;
                    end
                end else begin
                    m_gap++;
                    if (m_gap == TO) begin
                        m_coll = 0; m_terr = 1;
                    end
                end
            end else if (m_fill && bus_if.fill_ready) begin
                m_fill = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("miss_ready",    DW'(bus_if.miss_ready),    DW'(!m_busy()));
            check("mem_req_valid", DW'(bus_if.mem_req_valid), DW'(m_req));
            check("mem_req_addr",  DW'(bus_if.mem_req_addr),  DW'(m_addr));
            check("fill_valid",    DW'(bus_if.fill_valid),    DW'(m_fill));
            check("fill_addr",     DW'(bus_if.fill_addr),     DW'(m_addr));
            check("fill_data",     bus_if.fill_data,          m_line);
            check("busy",          DW'(bus_if.busy),          DW'(m_busy()));
            check("timeout_err",   DW'(bus_if.timeout_err),   DW'(m_terr));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_miss(input logic [AW-1:0] addr);
        bus_if.miss_valid = 1'b1;
        bus_if.miss_addr  = addr;
        tick();
        bus_if.miss_valid = 1'b0;
        bus_if.miss_addr  = $urandom;
    endtask

    task automatic req_hs(input int delay, input bit strays);
        for (int i = 0; i < delay; i++) begin
            bus_if.mem_req_ready = 1'b0;
            bus_if.mem_rsp_valid = strays ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_if.mem_rsp_data  = $urandom;
            tick();
        end
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.mem_req_ready = 1'b1;
        tick();
        bus_if.mem_req_ready = 1'b0;
    endtask

    task automatic send_beat(input logic [MDW-1:0] data, input int gap);
        for (int i = 0; i < gap; i++) begin
            bus_if.mem_rsp_valid = 1'b0;
            bus_if.mem_rsp_data  = $urandom;
            tick();
        end
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.mem_rsp_data  = data;
        tick();
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.mem_rsp_data  = $urandom;
    endtask

    task automatic fill_hs(input int delay);
        for (int i = 0; i < delay; i++) begin
            bus_if.fill_ready = 1'b0;
            tick();
        end
        bus_if.fill_ready = 1'b1;
        for (int i = 0; i < 20 && m_busy(); i++) tick();
        check("fill_wait_bound", DW'(m_busy()), DW'(1'b0));
        bus_if.fill_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc, pulses, fv;
        reset                = 1'b1;
        bus_if.miss_valid    = 1'b0;
        bus_if.miss_addr     = '0;
        bus_if.mem_req_ready = 1'b0;
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.mem_rsp_data  = '0;
        bus_if.fill_ready    = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        check("rst_miss_ready", DW'(bus_if.miss_ready),    DW'(1'b1));
        check("rst_busy",       DW'(bus_if.busy),          DW'(1'b0));
        check("rst_req_valid",  DW'(bus_if.mem_req_valid), DW'(1'b0));
        check("rst_fill_data",  bus_if.fill_data,          DW'(0));
        reset = 1'b0;
        tick();

        // Basic refill, back-to-back beats, minimum latency
        bus_if.fill_ready    = 1'b1;
        bus_if.mem_req_ready = 1'b1;
        bus_if.miss_valid    = 1'b1;
        bus_if.miss_addr     = 32'h0000_1238;
        acc_cyc              = cyc_n;
        tick();
        bus_if.miss_valid = 1'b0;
        check("basic_req_addr", DW'(bus_if.mem_req_addr), DW'(32'h0000_1230));
        tick();
        bus_if.mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(32'h1111_1111 * 32'(k + 1), 0);
        check("basic_fill_valid", DW'(bus_if.fill_valid), DW'(1'b1));
        check("basic_latency", DW'(cyc_n - acc_cyc), DW'(6));
        check("basic_fill_addr", DW'(bus_if.fill_addr), DW'(32'h0000_1230));
        check("basic_fill_data", bus_if.fill_data, 128'h44444444_33333333_22222222_11111111);
        tick();
        bus_if.fill_ready = 1'b0;
        check("basic_ready_after", DW'(bus_if.miss_ready), DW'(1'b1));

        // Request backpressure with stray beats before the handshake
        send_miss(32'h0000_ABCC);
        for (int i = 0; i < 5; i++) begin
            bus_if.mem_rsp_valid = 1'b1;
            bus_if.mem_rsp_data  = 32'hDEAD_BEEF;
            check("bp_req_valid", DW'(bus_if.mem_req_valid), DW'(1'b1));
            check("bp_req_addr",  DW'(bus_if.mem_req_addr),  DW'(32'h0000_ABC0));
            tick();
        end
        bus_if.mem_rsp_valid = 1'b0;
        req_hs(0, 1'b0);
        for (int k = 0; k < 4; k++) send_beat(32'hB000_0000 + 32'(k), 0);
        check("bp_fill_data", bus_if.fill_data, 128'hB0000003_B0000002_B0000001_B0000000);
        fill_hs(0);

        // Gapped beats and fill backpressure
        send_miss(32'h0000_7777);
        req_hs(0, 1'b0);
        for (int k = 0; k < 4; k++) send_beat(32'hA0A0_0001 + 32'(k), 3);
        for (int i = 0; i < 4; i++) begin
            check("gap_fill_valid", DW'(bus_if.fill_valid), DW'(1'b1));
            check("gap_fill_data",  bus_if.fill_data, 128'hA0A00004_A0A00003_A0A00002_A0A00001);
            check("gap_miss_ready", DW'(bus_if.miss_ready), DW'(1'b0));
            tick();
        end
        bus_if.fill_ready = 1'b1;
        tick();
        bus_if.fill_ready = 1'b0;
        check("gap_ready_after", DW'(bus_if.miss_ready), DW'(1'b1));

        // Timeout after two beats, then a clean refill
        send_miss(32'h0000_2000);
        req_hs(0, 1'b0);
        send_beat(32'h0BAD_0000, 0);
        send_beat(32'h0BAD_0001, 0);
        pulses = 0; fv = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus_if.timeout_err) pulses++;
            if (bus_if.fill_valid)  fv++;
        end
        check("to_pulses",     DW'(pulses), DW'(1));
        check("to_no_fill",    DW'(fv), DW'(0));
        check("to_miss_ready", DW'(bus_if.miss_ready), DW'(1'b1));
        send_miss(32'h0000_0040);
        req_hs(0, 1'b0);
        for (int k = 0; k < 4; k++) send_beat(32'h0000_00C0 + 32'(k), 0);
        check("to_new_addr", DW'(bus_if.fill_addr), DW'(32'h0000_0040));
        check("to_new_data", bus_if.fill_data, 128'h000000C3_000000C2_000000C1_000000C0);
        fill_hs(0);

        // Stray response in IDLE and stray miss in COLLECT
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.mem_rsp_data  = 32'hDEAD_BEEF;
        tick(); tick();
        bus_if.mem_rsp_valid = 1'b0;
        check("stray_idle_data", bus_if.fill_data, 128'h000000C3_000000C2_000000C1_000000C0);
        send_miss(32'h0000_0300);
        req_hs(0, 1'b0);
        send_beat(32'h5555_0000, 0);
        bus_if.miss_valid = 1'b1;
        bus_if.miss_addr  = 32'h0000_0999;
        send_beat(32'h5555_0001, 2);
        send_beat(32'h5555_0002, 0);
        bus_if.miss_valid = 1'b0;
        send_beat(32'h5555_0003, 1);
        check("stray_fill_addr", DW'(bus_if.fill_addr), DW'(32'h0000_0300));
        check("stray_fill_data", bus_if.fill_data, 128'h55550003_55550002_55550001_55550000);
        fill_hs(1);

        // Reset in the middle of COLLECT
        send_miss(32'h0000_0500);
        req_hs(0, 1'b0);
        send_beat(32'h6666_0000, 0);
        send_beat(32'h6666_0001, 0);
        reset = 1'b1;
        tick();
        check("mrst_busy",       DW'(bus_if.busy),       DW'(1'b0));
        check("mrst_fill_valid", DW'(bus_if.fill_valid), DW'(1'b0));
        check("mrst_fill_data",  bus_if.fill_data,       DW'(0));
        check("mrst_miss_ready", DW'(bus_if.miss_ready), DW'(1'b1));
        reset = 1'b0;
        tick();

        // Randomized refills, including occasional timeouts and stray inputs
        for (int t = 0; t < 40; t++) begin
            bus_if.mem_rsp_valid = 1'($urandom_range(0, 1));
            bus_if.mem_rsp_data  = $urandom;
            tick();
            bus_if.mem_rsp_valid = 1'b0;
            send_miss($urandom);
            req_hs(int'($urandom_range(0, 3)), 1'b1);
            for (int k = 0; k < 4; k++) begin
                send_beat($urandom, ($urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(0, 3)));
            end
            fill_hs(int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
